// File: rtl/loader_write_buffer.sv
// Write buffer between the JTAG loader and the memory write port.
// Queues unthrottled loader writes and holds the core in reset until they drain.
module loader_write_buffer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        loader_we,
    input  logic [31:0] loader_addr,
    input  logic [31:0] loader_data,
    input  logic        loader_reset,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic        mem_ready,
    output logic        core_reset,
    output logic        overflow,
    output logic [15:0] words_written
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [29:0]   addr_q [FIFO_DEPTH];
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    assign full = (count == FULL_CNT);
    assign pop  = mem_valid && mem_ready;
    assign push = loader_we && (!full || pop);
    assign drop = loader_we && full && !pop;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + ONE_CNT;
            2'b01:   count_next = count - ONE_CNT;
            default: count_next = count;
        endcase
    end

    assign mem_valid = (count != '0);
    assign mem_addr  = {addr_q[rd_ptr], 2'b00};
    assign mem_data  = data_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            words_written <= 16'd0;
            core_reset    <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_PTR;
            if (pop) begin
                rd_ptr        <= rd_ptr + ONE_PTR;
                words_written <= words_written + 16'd1;
            end
            if (drop) overflow <= 1'b1;
            count      <= count_next;
            core_reset <= loader_reset | loader_we | (count_next != '0);
        end
    end

    // Entry storage carries no reset; contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= loader_addr[31:2];
            data_q[wr_ptr] <= loader_data;
        end
    end

endmodule

// File: tb/tb_loader_write_buffer.sv
// Directed testbench for loader_write_buffer.
// Each task drives one scenario and checks outputs against hand-computed values.
module tb_loader_write_buffer;

    logic        clk;
    logic        reset_n;
    logic        loader_we;
    logic [31:0] loader_addr;
    logic [31:0] loader_data;
    logic        loader_reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        core_reset;
    logic        overflow;
    logic [15:0] words_written;

    int vectors;
    int miscompares;

    loader_write_buffer #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .loader_we    (loader_we),
        .loader_addr  (loader_addr),
        .loader_data  (loader_data),
        .loader_reset (loader_reset),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .core_reset   (core_reset),
        .overflow     (overflow),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        loader_we    = 1'b0;
        loader_reset = 1'b0;
        mem_ready    = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (mem_valid !== 1'b0 || overflow !== 1'b0 ||
            words_written !== 16'd0 || core_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: valid=%b ovf=%b ww=%0d crst=%b want 0 0 0 1",
                     mem_valid, overflow, words_written, core_reset);
        end
    endtask

    task automatic test_single();
        do_reset();
        mem_ready   = 1'b1;
        loader_we   = 1'b1;
        loader_addr = 32'h0000_0100;
        loader_data = 32'hDEAD_BEEF;
        tick();
        loader_we = 1'b0;
        vectors++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h100 ||
            mem_data !== 32'hDEAD_BEEF || core_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL single_head: v=%b a=%h d=%h crst=%b want 1 100 deadbeef 1",
                     mem_valid, mem_addr, mem_data, core_reset);
        end
        tick();
        vectors++;
        if (mem_valid !== 1'b0 || words_written !== 16'd1 ||
            core_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: v=%b ww=%0d crst=%b want 0 1 0",
                     mem_valid, words_written, core_reset);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            loader_we   = 1'b1;
            loader_addr = 32'(4 * i);
            loader_data = 32'(i + 1);
            tick();
        end
        loader_we = 1'b0;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h0 || mem_data !== 32'h1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: v=%b a=%h d=%h want 1 0 1",
                         c, mem_valid, mem_addr, mem_data);
            end
            tick();
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'(4 * i) ||
                mem_data !== 32'(i + 1)) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: v=%b a=%h d=%h want 1 %h %h",
                         i, mem_valid, mem_addr, mem_data, 4 * i, i + 1);
            end
            tick();
        end
        vectors++;
        if (mem_valid !== 1'b0 || words_written !== 16'd3) begin
            miscompares++;
            $display("FAIL bp_end: v=%b ww=%0d want 0 3", mem_valid, words_written);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            loader_we   = 1'b1;
            loader_addr = 32'(4 * i);
            loader_data = 32'(i);
            tick();
            vectors++;
            if (overflow !== (i == 9)) begin
                miscompares++;
                $display("FAIL ovf_push[%0d]: ovf=%b want %b", i, overflow, i == 9);
            end
        end
        loader_we = 1'b0;
        mem_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (mem_valid !== 1'b1 || mem_data !== 32'(i) || overflow !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_drain[%0d]: v=%b d=%h ovf=%b want 1 %h 1",
                         i, mem_valid, mem_data, overflow, i);
            end
            tick();
        end
        vectors++;
        if (mem_valid !== 1'b0 || overflow !== 1'b1 || words_written !== 16'd8) begin
            miscompares++;
            $display("FAIL ovf_end: v=%b ovf=%b ww=%0d want 0 1 8",
                     mem_valid, overflow, words_written);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp [8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            loader_we   = 1'b1;
            loader_addr = 32'(4 * i);
            loader_data = 32'(8'h10 + i);
            tick();
        end
        mem_ready   = 1'b1;
        loader_data = 32'hA5;
        tick();
        mem_ready = 1'b0;
        vectors++;
        if (overflow !== 1'b0 || mem_valid !== 1'b1 || mem_data !== 32'h11) begin
            miscompares++;
            $display("FAIL full_pop: ovf=%b v=%b d=%h want 0 1 11",
                     overflow, mem_valid, mem_data);
        end
        loader_data = 32'hBB;
        tick();
        loader_we = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL full_still8: ovf=%b want 1", overflow);
        end
        for (int i = 0; i < 7; i++) exp[i] = 32'(8'h11 + i);
        exp[7] = 32'hA5;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (mem_valid !== 1'b1 || mem_data !== exp[i]) begin
                miscompares++;
                $display("FAIL full_drain[%0d]: v=%b d=%h want 1 %h",
                         i, mem_valid, mem_data, exp[i]);
            end
            tick();
        end
        vectors++;
        if (mem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_end: v=%b want 0", mem_valid);
        end
    endtask

    task automatic test_core_reset_hold();
        do_reset();
        loader_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            loader_we   = 1'b1;
            loader_addr = 32'(4 * i);
            loader_data = 32'(i + 7);
            tick();
        end
        loader_we    = 1'b0;
        loader_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (core_reset !== 1'b1) begin
                miscompares++;
                $display("FAIL crst_hold[%0d]: crst=%b want 1", c, core_reset);
            end
        end
        mem_ready = 1'b1;
        tick();
        vectors++;
        if (core_reset !== 1'b1 || mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL crst_pop1: crst=%b v=%b want 1 1", core_reset, mem_valid);
        end
        tick();
        vectors++;
        if (core_reset !== 1'b0 || mem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL crst_pop2: crst=%b v=%b want 0 0", core_reset, mem_valid);
        end
    endtask

    task automatic test_misaligned_reset();
        do_reset();
        loader_we   = 1'b1;
        loader_addr = 32'h0000_0103;
        loader_data = 32'h55;
        tick();
        loader_we = 1'b0;
        vectors++;
        if (mem_addr !== 32'h100 || mem_data !== 32'h55) begin
            miscompares++;
            $display("FAIL misalign: a=%h d=%h want 100 55", mem_addr, mem_data);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            loader_we   = 1'b1;
            loader_addr = 32'(16 * i);
            loader_data = 32'(i);
            tick();
        end
        loader_we = 1'b0;
        vectors++;
        if (mem_valid !== 1'b1 || words_written !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_pre: v=%b ww=%0d want 1 1", mem_valid, words_written);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        vectors++;
        if (mem_valid !== 1'b0 || words_written !== 16'd0 || core_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: v=%b ww=%0d crst=%b want 0 0 1",
                     mem_valid, words_written, core_reset);
        end
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (mem_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_after[%0d]: v=%b want 0", c, mem_valid);
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        loader_we    = 1'b0;
        loader_addr  = 32'h0;
        loader_data  = 32'h0;
        loader_reset = 1'b0;
        mem_ready    = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_core_reset_hold();
        test_misaligned_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
